pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage MIPS32 pipeline. Drives enables and

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 42 ++++
 rtl/pipeline_hazard_ctrl_md_latency_counter.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: memory-wait FSM states,
// the bundle of stage enables/bubble controls, and the load-use comparator.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } ctrl_t;

    // Free-running pipeline: every stage loads, nothing is bubbled.
    localparam ctrl_t CTRL_RUN = '{
        pc_en:        1'b1,
        if_id_en:     1'b1,
        id_ex_en:     1'b1,
        ex_mem_en:    1'b1,
        if_id_flush:  1'b0,
        id_ex_flush:  1'b0,
        mem_wb_flush: 1'b0
    };

    localparam ctrl_t CTRL_OFF = '0;

    // $0 is hard-wired, so a load targeting it never creates a dependency.
    function automatic logic load_use(input logic       memread,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       uses_rt);
        return memread && (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_latency_counter.sv
// Tracks how long HI/LO stays occupied after a MULT/DIV issues from EX;
// a new start reloads the full latency even while a previous one is pending.
module md_latency_counter #(
    parameter int LATENCY = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    localparam int W = $clog2(LATENCY);
    localparam logic [W-1:0] LOAD_VAL = W'(LATENCY - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS32 pipeline: memory wait
// states with timeout, taken branches, load-use / HI-LO hazards and jumps.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY  = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_uses_hilo,
    input  logic        id_jump,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        ex_md_start,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic        md_busy,
    output logic        bus_err,
    output logic [15:0] stall_cycles
);

    localparam int WW = $clog2(MEM_TIMEOUT);

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          mem_stall;
    logic          data_hazard;
    ctrl_t         ctrl;

    assign timeout_hit = (state == MEM_WAIT) && !mem_ready && (wait_cnt == WW'(MEM_TIMEOUT - 1));
    assign mem_stall   = ((state == RUN) && mem_req && !mem_ready) ||
                         ((state == MEM_WAIT) && !mem_ready && !timeout_hit);
    assign data_hazard = load_use(ex_memread, ex_rd, id_rs, id_rt, id_uses_rt) ||
                         (md_busy && id_uses_hilo);

    // A frozen memory stage masks everything else; the younger hazards are
    // seen again on the release cycle because their stage registers held.
    always_comb begin
        ctrl = CTRL_RUN;
        if (!rst) begin
            ctrl = CTRL_OFF;
        end else if (mem_stall) begin
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_ex_en     = 1'b0;
            ctrl.ex_mem_en    = 1'b0;
            ctrl.mem_wb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
        end else if (data_hazard) begin
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_ex_flush  = 1'b1;
        end else if (id_jump) begin
            ctrl.if_id_flush  = 1'b1;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign id_ex_en     = ctrl.id_ex_en;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                    end else if (timeout_hit) begin
                        state   <= RUN;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

    md_latency_counter #(
        .LATENCY (MD_LATENCY)
    ) u_md_latency_counter (
        .clk  (clk),
        .rst  (rst),
        .load (ex_md_start && ex_mem_en),
        .busy (md_busy)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a table of single-cycle hazard
// vectors followed by hand-written multi-cycle memory, timeout and MUL/DIV sequences.
module tb_pipeline_hazard_ctrl;

    localparam int MD_LATENCY  = 32;
    localparam int MEM_TIMEOUT = 16;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush}
    localparam logic [6:0] NORMAL = 7'b1111_000;
    localparam logic [6:0] DHAZ   = 7'b0011_010;
    localparam logic [6:0] BR     = 7'b1111_110;
    localparam logic [6:0] JMP    = 7'b1111_100;
    localparam logic [6:0] MSTALL = 7'b0000_001;
    localparam logic [6:0] ALLOFF = 7'b0000_000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_uses_rt = 1'b0;
    logic        id_uses_hilo = 1'b0;
    logic        id_jump = 1'b0;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_branch_taken = 1'b0;
    logic        ex_md_start = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic        if_id_flush, id_ex_flush, mem_wb_flush;
    logic        md_busy, bus_err;
    logic [15:0] stall_cycles;
    logic [6:0]  ctrl_act;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       uses_hilo;
        logic       jump;
        logic       memread;
        logic [4:0] ex_rd;
        logic       br;
        logic       md_start;
        logic       req;
        logic       ready;
    } stim_t;

    typedef struct {
        string      name;
        logic [6:0] ctrl;
    } exp_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [6:0] ctrl;
    } vec_t;

    exp_t  sb[$];
    vec_t  vt[12];
    int    n_vec = 0;
    int    n_err = 0;
    stim_t idle_s;
    stim_t s;

    always #5 clk = ~clk;

    assign ctrl_act = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush};

    pipeline_hazard_ctrl #(
        .MD_LATENCY  (MD_LATENCY),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_uses_hilo    (id_uses_hilo),
        .id_jump         (id_jump),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_md_start     (ex_md_start),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_flush    (mem_wb_flush),
        .md_busy         (md_busy),
        .bus_err         (bus_err),
        .stall_cycles    (stall_cycles)
    );

    function automatic stim_t mk(input int rs, input int rt, input int uses_rt, input int hilo,
                                 input int jump, input int memread, input int rd, input int br,
                                 input int md, input int req, input int ready);
        stim_t r;
        r.rs        = rs[4:0];
        r.rt        = rt[4:0];
        r.uses_rt   = (uses_rt != 0);
        r.uses_hilo = (hilo != 0);
        r.jump      = (jump != 0);
        r.memread   = (memread != 0);
        r.ex_rd     = rd[4:0];
        r.br        = (br != 0);
        r.md_start  = (md != 0);
        r.req       = (req != 0);
        r.ready     = (ready != 0);
        return r;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input string name, input stim_t st, input logic [6:0] ctrl);
        exp_t e;
        id_rs           = st.rs;
        id_rt           = st.rt;
        id_uses_rt      = st.uses_rt;
        id_uses_hilo    = st.uses_hilo;
        id_jump         = st.jump;
        ex_memread      = st.memread;
        ex_rd           = st.ex_rd;
        ex_branch_taken = st.br;
        ex_md_start     = st.md_start;
        mem_req         = st.req;
        mem_ready       = st.ready;
        e.name = name;
        e.ctrl = ctrl;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
        end else begin
            e = sb.pop_front();
            compare(e.name, {25'd0, ctrl_act}, {25'd0, e.ctrl});
        end
    endtask

    // Drive on the falling edge, sample the Mealy outputs 1 ns later.
    task automatic cycle(input string name, input stim_t st, input logic [6:0] ctrl);
        @(negedge clk);
        applyStimulus(name, st, ctrl);
        #1;
        checkOutput();
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("reset_ctrl", idle_s, ALLOFF);
        #1;
        checkOutput();
        compare("reset_md_busy", {31'd0, md_busy}, 32'd0);
        compare("reset_bus_err", {31'd0, bus_err}, 32'd0);
        compare("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle_s = '0;

        vt[0]  = '{"idle",          mk(0,0,0,0,0,0,0,0,0,0,0), NORMAL};
        vt[1]  = '{"lu_rs",         mk(8,3,1,0,0,1,8,0,0,0,0), DHAZ};
        vt[2]  = '{"lu_rd0",        mk(0,0,1,0,0,1,0,0,0,0,0), NORMAL};
        vt[3]  = '{"lu_rt",         mk(4,9,1,0,0,1,9,0,0,0,0), DHAZ};
        vt[4]  = '{"lu_rt_unused",  mk(4,9,0,0,0,1,9,0,0,0,0), NORMAL};
        vt[5]  = '{"no_load",       mk(8,8,1,0,0,0,8,0,0,0,0), NORMAL};
        vt[6]  = '{"branch",        mk(1,2,1,0,0,0,5,1,0,0,0), BR};
        vt[7]  = '{"jump",          mk(1,2,1,0,1,0,5,0,0,0,0), JMP};
        vt[8]  = '{"br_jmp_lu",     mk(8,2,1,0,1,1,8,1,0,0,0), BR};
        vt[9]  = '{"lu_defers_jmp", mk(8,2,1,0,1,1,8,0,0,0,0), DHAZ};
        vt[10] = '{"mem_hit",       mk(0,0,0,0,0,0,0,0,0,1,1), NORMAL};
        vt[11] = '{"hilo_idle",     mk(0,0,0,1,0,0,0,0,0,0,0), NORMAL};

        applyReset();
        for (int i = 0; i < 12; i++) begin
            cycle(vt[i].name, vt[i].s, vt[i].ctrl);
        end
        cycle("table_tail", idle_s, NORMAL);
        compare("table_stall_cycles", {16'd0, stall_cycles}, 32'd3);

        // Three wait cycles (hazards ignored while frozen), branch honoured on release.
        applyReset();
        cycle("mw0", mk(0,0,0,0,0,0,0,0,0,1,0), MSTALL);
        cycle("mw1_hazards_ignored", mk(8,2,1,0,1,1,8,1,0,1,0), MSTALL);
        cycle("mw2", mk(0,0,0,0,0,0,0,0,0,1,0), MSTALL);
        cycle("mw_release_branch", mk(0,0,0,0,0,0,0,1,0,1,1), BR);
        cycle("mw_after", idle_s, NORMAL);
        compare("mw_stall_cycles", {16'd0, stall_cycles}, 32'd3);
        compare("mw_bus_err", {31'd0, bus_err}, 32'd0);

        // Memory never answers: forced release on the 17th cycle of the request.
        applyReset();
        for (int i = 0; i <= MEM_TIMEOUT; i++) begin
            cycle($sformatf("to_%0d", i), mk(0,0,0,0,0,0,0,0,0,1,0),
                  (i < MEM_TIMEOUT) ? MSTALL : NORMAL);
            compare($sformatf("to_bus_err_%0d", i), {31'd0, bus_err}, 32'd0);
        end
        cycle("to_after", idle_s, NORMAL);
        compare("to_bus_err_set", {31'd0, bus_err}, 32'd1);
        compare("to_stall_cycles", {16'd0, stall_cycles}, 32'd16);
        repeat (3) cycle("to_idle", idle_s, NORMAL);
        compare("to_bus_err_sticky", {31'd0, bus_err}, 32'd1);

        // MULT frozen by a wait state must not load; MFHI from k=5 stalls while busy.
        applyReset();
        cycle("md_start_frozen", mk(0,0,0,0,0,0,0,0,1,1,0), MSTALL);
        cycle("md_start_release", mk(0,0,0,0,0,0,0,0,1,1,1), NORMAL);
        compare("md_no_load_frozen", {31'd0, md_busy}, 32'd0);
        for (int k = 1; k <= 34; k++) begin
            logic exp_busy;
            s = idle_s;
            s.uses_hilo = (k >= 5);
            exp_busy = (k <= MD_LATENCY - 1);
            cycle($sformatf("md_k%0d", k), s, (s.uses_hilo && exp_busy) ? DHAZ : NORMAL);
            compare($sformatf("md_busy_k%0d", k), {31'd0, md_busy}, {31'd0, exp_busy});
        end
        compare("md_stall_cycles", {16'd0, stall_cycles}, 32'd28);

        // Restart while busy extends the busy window to 31 cycles after the second start.
        cycle("md_s1", mk(0,0,0,0,0,0,0,0,1,0,0), NORMAL);
        repeat (10) cycle("md_gap", idle_s, NORMAL);
        cycle("md_s2", mk(0,0,0,0,0,0,0,0,1,0,0), NORMAL);
        for (int j = 1; j <= MD_LATENCY; j++) begin
            cycle("md_restart_idle", idle_s, NORMAL);
            compare($sformatf("md_restart_busy_j%0d", j), {31'd0, md_busy},
                    {31'd0, (j <= MD_LATENCY - 1)});
        end

        // Reset asserted in the middle of a wait state.
        applyReset();
        cycle("rmw0", mk(0,0,0,0,0,0,0,0,0,1,0), MSTALL);
        cycle("rmw1", mk(0,0,0,0,0,0,0,0,0,1,0), MSTALL);
        cycle("rmw2", mk(0,0,0,0,0,0,0,0,0,1,0), MSTALL);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("rmw_in_reset", mk(0,0,0,0,0,0,0,0,0,1,0), ALLOFF);
        #1;
        checkOutput();
        compare("rmw_stall_cleared", {16'd0, stall_cycles}, 32'd0);
        compare("rmw_bus_err", {31'd0, bus_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("rmw_back_in_run", idle_s, NORMAL);
        #1;
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
